// File: rtl/quad_sequencer_if.sv
// Handshake/configuration bundle for quad_sequencer.
// master: the controller driving run/config requests; slave: the sequencer.
interface quad_sequencer_if #(
  parameter int unsigned DIV_W = 8
) ();

  logic             en;
  logic [DIV_W-1:0] div;
  logic             dir;
  logic             cfg_load;
  logic             cfg_ack;
  logic [3:0]       quad_out;
  logic             running;
  logic             cycle_strobe;

  modport master (
    output en, div, dir, cfg_load,
    input  cfg_ack, quad_out, running, cycle_strobe
  );

  modport slave (
    input  en, div, dir, cfg_load,
    output cfg_ack, quad_out, running, cycle_strobe
  );

endinterface

// File: rtl/quad_sequencer.sv
// Four-phase quadrature switch sequencer.
// Each phase is one-hot on quad_out for (active div + 1) clocks; the order is
// 0001,0010,0100,1000 (dir=0) or 0001,1000,0100,0010 (dir=1). New div/dir are
// staged in a pending register and only take effect at a cycle boundary
// (or right away while idle).
// Optional feature: define QUAD_DEADTIME_EN to insert DEAD_CYCLES all-off
// clocks (GAP) after every phase, including the 3->0 wrap.
module quad_sequencer #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEAD_CYCLES = 1
) (
  input  logic           if_clk,
  input  logic           rst,
  quad_sequencer_if.slave bus
);

`ifdef QUAD_DEADTIME_EN
  typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;
  localparam logic [3:0] GapInit = 4'(DEAD_CYCLES - 1);
`else
  typedef enum logic [1:0] {StIdle, StOn} state_e;
`endif

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_div_q, act_div_d;
  logic             act_dir_q, act_dir_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_dir_q, pend_dir_d;
  logic             pend_vld_q, pend_vld_d;
  logic [3:0]       quad_q, quad_d;
`ifdef QUAD_DEADTIME_EN
  logic [3:0]       gap_q, gap_d;
`else
  // DEAD_CYCLES has no effect without dead time; keep it referenced.
  logic             unused_dead_cycles;
  assign unused_dead_cycles = ^DEAD_CYCLES;
`endif

  logic last_phase;
  logic on_done;
  logic boundary;
  logic load_now;
  logic apply;

  assign last_phase = (phase_q == 2'd3);
  assign on_done    = (state_q == StOn) && (cnt_q == '0);
`ifdef QUAD_DEADTIME_EN
  assign boundary   = (state_q == StGap) && (gap_q == 4'd0) && last_phase;
`else
  assign boundary   = on_done && last_phase;
`endif
  // A load arriving in the boundary clock bypasses the pending register.
  assign load_now   = boundary && bus.cfg_load;
  assign apply      = !rst && ((state_q == StIdle) ? pend_vld_q
                                                   : (boundary && (pend_vld_q || bus.cfg_load)));

  // State register with synchronous reset
  always_ff @(posedge if_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      phase_q    <= 2'd0;
      cnt_q      <= '0;
      act_div_q  <= '0;
      act_dir_q  <= 1'b0;
      pend_div_q <= '0;
      pend_dir_q <= 1'b0;
      pend_vld_q <= 1'b0;
      quad_q     <= 4'b0000;
`ifdef QUAD_DEADTIME_EN
      gap_q      <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      act_dir_q  <= act_dir_d;
      pend_div_q <= pend_div_d;
      pend_dir_q <= pend_dir_d;
      pend_vld_q <= pend_vld_d;
      quad_q     <= quad_d;
`ifdef QUAD_DEADTIME_EN
      gap_q      <= gap_d;
`endif
    end
  end

  // Next-state: config staging/apply and phase sequencing
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    act_dir_d  = act_dir_q;
    pend_div_d = pend_div_q;
    pend_dir_d = pend_dir_q;
    pend_vld_d = pend_vld_q;
`ifdef QUAD_DEADTIME_EN
    gap_d      = gap_q;
`endif

    if (apply) begin
      act_div_d  = load_now ? bus.div : pend_div_q;
      act_dir_d  = load_now ? bus.dir : pend_dir_q;
      pend_vld_d = 1'b0;
    end
    if (bus.cfg_load && !load_now) begin
      pend_div_d = bus.div;
      pend_dir_d = bus.dir;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (bus.en) begin
          state_d = StOn;
          phase_d = 2'd0;
          cnt_d   = act_div_d;
        end
      end
      StOn: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
`ifdef QUAD_DEADTIME_EN
        end else begin
          state_d = StGap;
          gap_d   = GapInit;
        end
`else
        end else if (last_phase) begin
          phase_d = 2'd0;
          cnt_d   = act_div_d;
          if (!bus.en) state_d = StIdle;
        end else begin
          phase_d = phase_q + 2'd1;
          cnt_d   = act_div_q;
        end
`endif
      end
`ifdef QUAD_DEADTIME_EN
      StGap: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (last_phase) begin
          state_d = bus.en ? StOn : StIdle;
          phase_d = 2'd0;
          cnt_d   = act_div_d;
        end else begin
          state_d = StOn;
          phase_d = phase_q + 2'd1;
          cnt_d   = act_div_q;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs: registered switch drive decoded from next state, strobes from current
  always_comb begin
    quad_d = 4'b0000;
    if (state_d == StOn) begin
      unique case (phase_d)
        2'd0: quad_d = 4'b0001;
        2'd1: quad_d = act_dir_d ? 4'b1000 : 4'b0010;
        2'd2: quad_d = 4'b0100;
        2'd3: quad_d = act_dir_d ? 4'b0010 : 4'b1000;
        default: quad_d = 4'b0000;
      endcase
    end
  end

  assign bus.quad_out     = quad_q;
  assign bus.running      = (state_q != StIdle);
  assign bus.cycle_strobe = boundary && !rst;
  assign bus.cfg_ack      = apply;

endmodule

// File: tb/tb_quad_sequencer.sv
module tb_quad_sequencer;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned DEAD  = 2;
`ifdef QUAD_DEADTIME_EN
  localparam int G = DEAD;
`else
  localparam int G = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quad_sequencer_if #(.DIV_W(DIV_W)) bus ();

  quad_sequencer #(
    .DIV_W      (DIV_W),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .if_clk(clk),
    .rst   (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position t inside a cycle of 4 slots, each slot being
  // (div+1) on-clocks followed by G off-clocks.
  bit m_run  = 0;
  int m_t    = 0;
  int m_div  = 0;
  bit m_dir  = 0;
  bit m_pv   = 0;
  int m_pdiv = 0;
  bit m_pdir = 0;

  function automatic logic [3:0] phase_code(int slot, bit d);
    logic [3:0] one;
    one = 4'b0001;
    if (!d || slot == 0) return one << slot;
    return one << (4 - slot);
  endfunction

  function automatic int slot_len();
    return m_div + 1 + G;
  endfunction

  function automatic bit m_bnd();
    return m_run && (m_t == 4 * slot_len() - 1);
  endfunction

  // Expected {quad_out, running, cycle_strobe, cfg_ack} for the current clock
  task automatic model_eval(output logic [6:0] ev);
    logic [3:0] q;
    bit ack;
    q = 4'b0000;
    if (m_run && (m_t % slot_len()) <= m_div) q = phase_code(m_t / slot_len(), m_dir);
    ack = m_run ? (m_bnd() && (m_pv || bus.cfg_load)) : m_pv;
    ev = {q, m_run, m_bnd() && !rst, ack && !rst};
  endtask

  // Advance the model across one rising edge using the inputs held there
  task automatic model_adv();
    bit bnd;
    bnd = m_bnd();
    if (rst) begin
      m_run = 0; m_t = 0; m_div = 0; m_dir = 0; m_pv = 0; m_pdiv = 0; m_pdir = 0;
    end else if (!m_run) begin
      if (m_pv) begin m_div = m_pdiv; m_dir = m_pdir; m_pv = 0; end
      if (bus.cfg_load) begin m_pdiv = int'(bus.div); m_pdir = bus.dir; m_pv = 1; end
      if (bus.en) begin m_run = 1; m_t = 0; end
    end else if (bnd) begin
      if (bus.cfg_load) begin m_div = int'(bus.div); m_dir = bus.dir; m_pv = 0; end
      else if (m_pv) begin m_div = m_pdiv; m_dir = m_pdir; m_pv = 0; end
      m_t = 0;
      if (!bus.en) m_run = 0;
    end else begin
      m_t++;
      if (bus.cfg_load) begin m_pdiv = int'(bus.div); m_pdir = bus.dir; m_pv = 1; end
    end
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.cfg_load = 1'b0; bus.div = '0; bus.dir = 1'b0;
    rst = 1'b1;
    @(posedge clk); model_adv(); #1;
    @(posedge clk); model_adv(); #1;
    @(negedge clk);
    n_vec++;
    if (bus.quad_out !== 4'b0000) begin
      n_err++; $display("FAIL reset_quad: got %b want 0000", bus.quad_out);
    end
    n_vec++;
    if ({bus.running, bus.cycle_strobe, bus.cfg_ack} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got run/strb/ack %b want 000",
               {bus.running, bus.cycle_strobe, bus.cfg_ack});
    end
    @(posedge clk); model_adv(); #1;
    rst = 1'b0;
  endtask

  // div=0 (or 1 with dead time), dir=0, continuous run
  task automatic test_basic();
    logic [6:0] ev, got;
    bus.cfg_load = 1'b1; bus.div = DIV_W'((G > 0) ? 1 : 0); bus.dir = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); model_eval(ev);
      got = {bus.quad_out, bus.running, bus.cycle_strobe, bus.cfg_ack};
      n_vec++;
      if (got !== ev) begin
        n_err++; $display("FAIL basic cyc %0d: got %b want %b (quad,run,strb,ack)", i, got, ev);
      end
      @(posedge clk); model_adv(); #1;
      bus.cfg_load = 1'b0;
      bus.en = (i >= 0);
    end
  endtask

  // switch to reverse order mid phase 1
  task automatic test_dir_switch();
    logic [6:0] ev, got;
    bit loaded = 0;
    bus.cfg_load = 1'b1; bus.div = DIV_W'(2); bus.dir = 1'b0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk); model_eval(ev);
      got = {bus.quad_out, bus.running, bus.cycle_strobe, bus.cfg_ack};
      n_vec++;
      if (got !== ev) begin
        n_err++; $display("FAIL dir_switch cyc %0d: got %b want %b", i, got, ev);
      end
      @(posedge clk); model_adv(); #1;
      bus.cfg_load = 1'b0;
      if (!loaded && m_div == 2 && m_run && m_t == slot_len() + 1) begin
        bus.cfg_load = 1'b1; bus.div = DIV_W'(2); bus.dir = 1'b1; loaded = 1;
      end
    end
  endtask

  // two loads before one boundary -> one ack, 6-clock phases
  task automatic test_double_load();
    logic [6:0] ev, got;
    int nld = 0;
    int acks = 0;
    bus.en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); model_eval(ev);
      got = {bus.quad_out, bus.running, bus.cycle_strobe, bus.cfg_ack};
      if (nld > 0 && bus.cfg_ack === 1'b1) acks++;
      n_vec++;
      if (got !== ev) begin
        n_err++; $display("FAIL double_load cyc %0d: got %b want %b", i, got, ev);
      end
      @(posedge clk); model_adv(); #1;
      bus.cfg_load = 1'b0;
      if (nld == 0 && m_t == 1) begin
        bus.cfg_load = 1'b1; bus.div = DIV_W'(3); bus.dir = 1'b0; nld = 1;
      end else if (nld == 1 && m_t == 3) begin
        bus.cfg_load = 1'b1; bus.div = DIV_W'(5); bus.dir = 1'b0; nld = 2;
      end
    end
    n_vec++;
    if (acks != 1) begin
      n_err++; $display("FAIL double_load_acks: got %0d want 1", acks);
    end
  endtask

  // en dropped during phase 1 -> finish cycle then idle
  task automatic test_stop();
    logic [6:0] ev, got;
    bit dropped = 0;
    bus.en = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk); model_eval(ev);
      got = {bus.quad_out, bus.running, bus.cycle_strobe, bus.cfg_ack};
      n_vec++;
      if (got !== ev) begin
        n_err++; $display("FAIL stop cyc %0d: got %b want %b", i, got, ev);
      end
      @(posedge clk); model_adv(); #1;
      if (!dropped && m_run && m_t == slot_len()) begin
        bus.en = 1'b0; dropped = 1;
      end
    end
    @(negedge clk);
    n_vec++;
    if ({bus.running, bus.quad_out} !== 5'b0) begin
      n_err++; $display("FAIL stop_idle: got run,quad %b want 00000", {bus.running, bus.quad_out});
    end
    @(posedge clk); model_adv(); #1;
  endtask

  // reset pulse in phase 2, then restart from 0001
  task automatic test_reset_mid();
    logic [6:0] ev, got;
    bit fired = 0;
    bit post = 0;
    bus.en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); model_eval(ev);
      got = {bus.quad_out, bus.running, bus.cycle_strobe, bus.cfg_ack};
      n_vec++;
      if (got !== ev) begin
        n_err++; $display("FAIL reset_mid cyc %0d: got %b want %b", i, got, ev);
      end
      if (post) begin
        n_vec++;
        if ({bus.running, bus.quad_out} !== 5'b0) begin
          n_err++; $display("FAIL reset_mid_clear: got %b want 00000", {bus.running, bus.quad_out});
        end
        post = 0;
      end
      @(posedge clk);
      post = rst;
      model_adv(); #1;
      rst = 1'b0;
      if (!fired && m_run && m_t == 2 * slot_len() + 1) begin
        rst = 1'b1; fired = 1;
      end
    end
  endtask

  // cfg_load in the boundary clock with en low: apply and stop together
  task automatic test_boundary_load();
    logic [6:0] ev, got;
    int since = -1;
    bus.en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); model_eval(ev);
      got = {bus.quad_out, bus.running, bus.cycle_strobe, bus.cfg_ack};
      n_vec++;
      if (got !== ev) begin
        n_err++; $display("FAIL bnd_load cyc %0d: got %b want %b", i, got, ev);
      end
      if (since == 0) begin
        n_vec++;
        if ({bus.cycle_strobe, bus.cfg_ack} !== 2'b11) begin
          n_err++; $display("FAIL bnd_load_ack: got strb,ack %b want 11",
                            {bus.cycle_strobe, bus.cfg_ack});
        end
      end
      @(posedge clk); model_adv(); #1;
      bus.cfg_load = 1'b0;
      if (since >= 0) since++;
      if (since < 0 && m_bnd()) begin
        bus.cfg_load = 1'b1; bus.div = DIV_W'(1); bus.dir = 1'b1; since = 0;
      end
      bus.en = !(since >= 0 && since < 4);
    end
  endtask

  task automatic test_random();
    logic [6:0] ev, got;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); model_eval(ev);
      got = {bus.quad_out, bus.running, bus.cycle_strobe, bus.cfg_ack};
      n_vec++;
      if (got !== ev) begin
        n_err++; $display("FAIL random cyc %0d: got %b want %b", i, got, ev);
      end
      @(posedge clk); model_adv(); #1;
      bus.en       = ($urandom_range(0, 15) != 0);
      bus.cfg_load = ($urandom_range(0, 9) == 0);
      bus.div      = DIV_W'($urandom_range(0, 3));
      bus.dir      = 1'($urandom_range(0, 1));
      rst          = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dir_switch();
    test_double_load();
    test_stop();
    test_reset_mid();
    test_boundary_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/quad_sequencer.md
QUAD_SEQUENCER -- requirements
Module: quad_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of the phase-length divider input.
REQ-002 SHALL have parameter DEAD_CYCLES, default 1, range 1..15: all-off clocks inserted at each phase transition when dead time is compiled in.
REQ-003 SHALL have port if_clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1: level run request.
REQ-006 SHALL have port div, input, DIV_W: requested phase length; each phase is held for div+1 clocks.
REQ-007 SHALL have port dir, input, 1: sequence direction; 0 selects forward (I leads), 1 selects reverse (sideband swap).
REQ-008 SHALL have port cfg_load, input, 1: single-cycle pulse that captures div and dir into the pending register.
REQ-009 SHALL have port cfg_ack, output, 1: single-cycle pulse when the pending configuration becomes active.
REQ-010 SHALL have port quad_out, output, 4: analog switch drives, registered.
REQ-011 SHALL have port running, output, 1: high when not IDLE.
REQ-012 SHALL have port cycle_strobe, output, 1: single-cycle pulse on completion of each full four-phase cycle.

Function
REQ-013 SHALL implement states IDLE, ON and GAP, where GAP exists only when QUAD_DEADTIME_EN is defined.
REQ-014 SHALL hold quad_out at 0000 in IDLE and GAP, and one-hot in ON; no other value is permitted.
REQ-015 SHALL move IDLE->ON with phase 0 when en=1, so quad_out=0001 in the clock after en is sampled high.
REQ-016 SHALL sequence phases as 0001,0010,0100,1000 when dir=0 and as 0001,1000,0100,0010 when dir=1, wrapping from phase 3 to phase 0.
REQ-017 SHALL hold each ON phase for exactly active_div+1 clocks, using a down-counter reloaded on phase entry.
REQ-018 SHALL, with dead time compiled in, insert exactly DEAD_CYCLES clocks of GAP between consecutive phases, including across the 3->0 wrap.
REQ-019 SHALL define the cycle boundary as the last clock of phase 3 (or of the following GAP); cycle_strobe pulses on that clock.
REQ-020 SHALL, when cfg_load is asserted, overwrite the pending div/dir; a later cfg_load before application replaces the earlier one and produces only one ack.
REQ-021 SHALL apply pending config only at a cycle boundary, pulsing cfg_ack in the same clock; in IDLE it applies in the clock after cfg_load.
REQ-022 SHALL, when en is low, finish the current cycle and enter IDLE at the boundary; if en returns high before the boundary, the block continues without interruption.
REQ-023 SHALL give cfg_load in the boundary clock priority over the stop, so both the apply and the stop occur in that clock.
REQ-024 SHALL allow div=0, which produces one clock per phase, so quad_out frequency = if_clk/4.

Reset
REQ-025 SHALL, on rst=1 at any edge including mid-phase, force the next state to be IDLE, quad_out=0000, running=0, cfg_ack=0, cycle_strobe=0, active div=0, active dir=0 and pending cleared.
REQ-026 SHALL give rst priority over en and cfg_load.

Configuration
REQ-027 SHALL, with QUAD_DEADTIME_EN defined, include the GAP state and dead-time counter per REQ-018.
REQ-028 SHALL, with QUAD_DEADTIME_EN undefined, omit GAP logic so phases are back-to-back; DEAD_CYCLES is then ignored.

Verification
REQ-029 SHALL cover: macro off, div=0, dir=0, en=1 -> quad_out 0001,0010,0100,1000 repeating every 4 clocks, cycle_strobe every 4th clock.
REQ-030 SHALL cover: macro on, DEAD_CYCLES=2, div=1 -> 0001 for 2 clocks, 0000 for 2 clocks, 0010 for 2 clocks, and so on; period 16 clocks.
REQ-031 SHALL cover: running with dir=0, then cfg_load with dir=1 mid-phase-1 -> forward order continues to the boundary, then cfg_ack, then 0001,1000,0100,0010.
REQ-032 SHALL cover: en dropped during phase 1 -> phases 2 and 3 complete, running=0 after the boundary, quad_out=0000.
REQ-033 SHALL cover: rst pulsed during phase 2 -> quad_out=0000 and running=0 on the next edge; restart begins at 0001.
REQ-034 SHALL cover: two cfg_load pulses (div=3, then div=5) before the boundary -> a single cfg_ack, and phases last 6 clocks.
